parking_gate_ctrl: RTL and testbench

//  Parametrised successor to the single-gate parking controller.
//  - Gates car entry with a configurable-width password and counts cars up to CAPACITY.
//  - Adds features the first generation lacks: a full flag, departure tracking, retry limit

---
 rtl/parking_gate_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
//   Entrance-gate controller for a parking lot. A car at the entrance must key
//   in the password before the gate opens. The block counts cars in the lot up
//   to CAPACITY and tracks departures. It locks the keypad out for a fixed
//   time after MAX_TRIES consecutive wrong entries. It abandons a password
//   wait after TIMEOUT_CYC idle cycles.
//
// Ports
//   clk             in   1      system clock, rising edge
//   reset           in   1      asynchronous, active-high reset
//   sensor_entrance in   1      car present at entrance gate (level)
//   sensor_exit     in   1      car has cleared the gate into the lot (level)
//   car_depart      in   1      one-cycle pulse: a car left the lot
//   password_valid  in   1      one-cycle strobe: password holds a full entry
//   password        in   PWD_W  keypad value, sampled when password_valid=1
//   GREEN_LED       out  1      gate open
//   RED_LED         out  1      gate closed / error
//   indicator       out  3      current state code
//   countcar        out  CNT_W  cars currently in lot
//   full            out  1      countcar == CAPACITY
//   lockout         out  1      keypad locked out
// -----------------------------------------------------------------------------
module parking_gate_ctrl #(
  parameter int               CAPACITY    = 8,
  parameter int               PWD_W       = 4,
  parameter logic [PWD_W-1:0] PASSWORD    = 4'b1011,
  parameter int               MAX_TRIES   = 3,
  parameter int               LOCKOUT_CYC = 16,
  parameter int               TIMEOUT_CYC = 64,
  localparam int              CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_entrance,
  input  logic             sensor_exit,
  input  logic             car_depart,
  input  logic             password_valid,
  input  logic [PWD_W-1:0] password,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic [2:0]       indicator,
  output logic [CNT_W-1:0] countcar,
  output logic             full,
  output logic             lockout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_PASS  = 3'd1,
    S_WRONG_PASS = 3'd2,
    S_RIGHT_PASS = 3'd3,
    S_STOP       = 3'd4,
    S_LOCKOUT    = 3'd5
  } state_e;

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  // One timer serves both the password timeout and the lockout hold.
  localparam int TMR_MAX = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0]   TMO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]   LOCK_LAST = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TRIES_W-1:0] TRY_LIMIT = TRIES_W'(MAX_TRIES);

  state_e             state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               green_q, green_d;
  logic               red_q, red_d;

  logic               full_now;
  logic               pw_match;
  logic               car_in;
  logic [TRIES_W-1:0] tries_inc;

  assign full_now  = (count_q == CNT_FULL);
  assign pw_match  = (password == PASSWORD);
  assign car_in    = (state_q == S_RIGHT_PASS) && sensor_exit;
  assign tries_inc = tries_q + TRIES_W'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    tries_d = tries_q;
    timer_d = timer_q;
    count_d = count_q;
    green_d = 1'b0;
    red_d   = 1'b0;

    // Arrival and departure in the same cycle cancel out. Otherwise the count
    // saturates at CAPACITY and floors at zero.
    if (car_in && !car_depart) begin
      if (!full_now) count_d = count_q + CNT_W'(1);
    end else if (car_depart && !car_in) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (sensor_entrance && !full_now) begin
          state_d = S_WAIT_PASS;
          timer_d = '0;
        end
      end

      S_WAIT_PASS, S_WRONG_PASS, S_STOP: begin
        if (state_q == S_STOP && full_now) begin
          // A tailgater filled the lot: the keypad is dead until a space frees up.
          if (car_depart) state_d = S_IDLE;
        end else if (password_valid) begin
          if (pw_match) begin
            state_d = S_RIGHT_PASS;
            tries_d = '0;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRY_LIMIT) begin
              state_d = S_LOCKOUT;
              timer_d = '0;
            end else begin
              state_d = S_WRONG_PASS;
            end
          end
        end else if (state_q == S_WAIT_PASS) begin
          if (timer_q == TMO_LAST) begin
            state_d = S_IDLE;
            tries_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end

      S_RIGHT_PASS: begin
        if (sensor_exit) state_d = sensor_entrance ? S_STOP : S_IDLE;
      end

      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = S_IDLE;
          tries_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // LEDs are decoded from the next state so they register alongside it.
    case (state_d)
      S_IDLE:       red_d   = (count_d == CNT_FULL);
      S_RIGHT_PASS: green_d = 1'b1;
      // Blink starts lit on entry, then inverts every cycle while wrong.
      S_WRONG_PASS: red_d   = (state_q == S_WRONG_PASS) ? ~red_q : 1'b1;
      default:      red_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tries_q <= '0;
      timer_q <= '0;
      count_q <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      count_q <= count_d;
      green_q <= green_d;
      red_q   <= red_d;
    end
  end

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign indicator = state_q;
  assign countcar  = count_q;
  assign full      = full_now;
  assign lockout   = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;

  localparam logic [3:0] PW_OK  = 4'b1011;
  localparam logic [3:0] PW_BAD = 4'b1001;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_entrance, sensor_exit, car_depart, password_valid;
  logic [3:0] password;
  logic       GREEN_LED, RED_LED, full, lockout;
  logic [2:0] indicator;
  logic [3:0] countcar;

  int n_checks = 0;
  int n_errors = 0;
  int cnt      = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       g;
    logic       r;
    logic [3:0] cnt;
    logic       lk;
  } exp_t;

  exp_t sb_q[$];

  parking_gate_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .car_depart      (car_depart),
    .password_valid  (password_valid),
    .password        (password),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .indicator       (indicator),
    .countcar        (countcar),
    .full            (full),
    .lockout         (lockout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ind"},   32'(indicator), 0);
    check({tag, "_green"}, 32'(GREEN_LED), 0);
    check({tag, "_red"},   32'(RED_LED),   0);
    check({tag, "_cnt"},   32'(countcar),  0);
    check({tag, "_full"},  32'(full),      0);
    check({tag, "_lock"},  32'(lockout),   0);
  endtask

  // Drive one cycle of stimulus, enqueue what the lot should look like after
  // the edge, then pop and compare once the DUT has had its clock edge.
  task automatic step(input string tag, input logic ent, input logic ex, input logic dep,
                      input logic pv, input logic [3:0] pw,
                      input logic [2:0] st, input logic g, input logic r,
                      input int c, input logic lk);
    exp_t e;
    @(negedge clk);
    sensor_entrance = ent;
    sensor_exit     = ex;
    car_depart      = dep;
    password_valid  = pv;
    password        = pw;
    e.st  = st;
    e.g   = g;
    e.r   = r;
    e.cnt = 4'(c);
    e.lk  = lk;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, "_ind"},   32'(indicator), 32'(e.st));
    check({tag, "_green"}, 32'(GREEN_LED), 32'(e.g));
    check({tag, "_red"},   32'(RED_LED),   32'(e.r));
    check({tag, "_cnt"},   32'(countcar),  32'(e.cnt));
    check({tag, "_lock"},  32'(lockout),   32'(e.lk));
    check({tag, "_full"},  32'(full),      32'(e.cnt == 4'd8));
  endtask

  // Normal admission of one car: entrance, good password, drive through.
  task automatic admit(input string tag);
    step({tag, "_ent"},  1, 0, 0, 0, 4'h0,  3'd1, 0, 1, cnt, 0);
    step({tag, "_pw"},   0, 0, 0, 1, PW_OK, 3'd3, 1, 0, cnt, 0);
    cnt++;
    step({tag, "_exit"}, 0, 1, 0, 0, 4'h0,  3'd0, 0, (cnt == 8), cnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    sensor_entrance = 0; sensor_exit = 0; car_depart = 0;
    password_valid = 0; password = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Departure with an empty lot must not wrap.
    step("dep_at_zero", 0, 0, 1, 0, 4'h0, 3'd0, 0, 0, 0, 0);

    // Basic admission, including a hold in RIGHT_PASS until the exit sensor.
    step("t1_ent",  1, 0, 0, 0, 4'h0,  3'd1, 0, 1, 0, 0);
    step("t1_pw",   1, 0, 0, 1, PW_OK, 3'd3, 1, 0, 0, 0);
    step("t1_hold", 0, 0, 0, 0, 4'h0,  3'd3, 1, 0, 0, 0);
    step("t1_exit", 0, 1, 0, 0, 4'h0,  3'd0, 0, 0, 1, 0);
    cnt = 1;

    // Arrival and departure on the same edge leave the count alone.
    step("t5_ent",  1, 0, 0, 0, 4'h0,  3'd1, 0, 1, 1, 0);
    step("t5_pw",   0, 0, 0, 1, PW_OK, 3'd3, 1, 0, 1, 0);
    step("t5_both", 0, 1, 1, 0, 4'h0,  3'd0, 0, 0, 1, 0);

    // Three wrong entries lock the keypad; red blinks while in WRONG_PASS.
    step("t2_ent",   1, 0, 0, 0, 4'h0,   3'd1, 0, 1, 1, 0);
    step("t2_bad1",  1, 0, 0, 1, PW_BAD, 3'd2, 0, 1, 1, 0);
    step("t2_blink", 1, 0, 0, 0, 4'h0,   3'd2, 0, 0, 1, 0);
    step("t2_bad2",  1, 0, 0, 1, PW_BAD, 3'd2, 0, 1, 1, 0);
    step("t2_bad3",  1, 0, 0, 1, PW_BAD, 3'd5, 0, 1, 1, 1);
    for (int i = 0; i < 15; i++)
      step("t2_locked", 1, 1, 0, 1, PW_OK, 3'd5, 0, 1, 1, 1);
    step("t2_unlock", 0, 0, 0, 0, 4'h0, 3'd0, 0, 0, 1, 0);
    // Tries were cleared: two more wrong entries do not lock out.
    step("t2b_ent",  1, 0, 0, 0, 4'h0,   3'd1, 0, 1, 1, 0);
    step("t2b_bad1", 0, 0, 0, 1, PW_BAD, 3'd2, 0, 1, 1, 0);
    step("t2b_bad2", 0, 0, 0, 1, PW_BAD, 3'd2, 0, 0, 1, 0);
    step("t2b_pw",   0, 0, 0, 1, PW_OK,  3'd3, 1, 0, 1, 0);
    step("t2b_exit", 0, 1, 0, 0, 4'h0,   3'd0, 0, 0, 2, 0);
    cnt = 2;

    // Tailgater: STOP, then good password reopens the gate.
    step("t4_ent",  1, 0, 0, 0, 4'h0,  3'd1, 0, 1, 2, 0);
    step("t4_pw",   0, 0, 0, 1, PW_OK, 3'd3, 1, 0, 2, 0);
    step("t4_tail", 1, 1, 0, 0, 4'h0,  3'd4, 0, 1, 3, 0);
    step("t4_stpw", 0, 0, 0, 1, PW_OK, 3'd3, 1, 0, 3, 0);
    step("t4_exit", 0, 1, 0, 0, 4'h0,  3'd0, 0, 0, 4, 0);
    // Tailgater then wrong password goes to WRONG_PASS.
    step("t4b_ent",  1, 0, 0, 0, 4'h0,  3'd1, 0, 1, 4, 0);
    step("t4b_pw",   0, 0, 0, 1, PW_OK, 3'd3, 1, 0, 4, 0);
    step("t4b_tail", 1, 1, 0, 0, 4'h0,  3'd4, 0, 1, 5, 0);
    step("t4b_bad",  0, 0, 0, 1, 4'h0,  3'd2, 0, 1, 5, 0);
    step("t4b_pw2",  0, 0, 0, 1, PW_OK, 3'd3, 1, 0, 5, 0);
    step("t4b_exit", 0, 1, 0, 0, 4'h0,  3'd0, 0, 0, 6, 0);
    cnt = 6;

    // Fill to capacity; a full lot refuses entry until someone leaves.
    admit("fill7");
    admit("fill8");
    step("t3_refuse", 1, 0, 0, 0, 4'h0, 3'd0, 0, 1, 8, 0);
    step("t3_depart", 0, 0, 1, 0, 4'h0, 3'd0, 0, 0, 7, 0);

    // Tailgater fills the lot: STOP ignores the keypad, a departure frees it.
    step("sf_ent",    1, 0, 0, 0, 4'h0,  3'd1, 0, 1, 7, 0);
    step("sf_pw",     0, 0, 0, 1, PW_OK, 3'd3, 1, 0, 7, 0);
    step("sf_tail",   1, 1, 0, 0, 4'h0,  3'd4, 0, 1, 8, 0);
    step("sf_ignore", 0, 0, 0, 1, PW_OK, 3'd4, 0, 1, 8, 0);
    step("sf_depart", 0, 0, 1, 0, 4'h0,  3'd0, 0, 0, 7, 0);

    // Asynchronous reset in the middle of RIGHT_PASS.
    step("t6_dep1", 0, 0, 1, 0, 4'h0,  3'd0, 0, 0, 6, 0);
    step("t6_dep2", 0, 0, 1, 0, 4'h0,  3'd0, 0, 0, 5, 0);
    step("t6_ent",  1, 0, 0, 0, 4'h0,  3'd1, 0, 1, 5, 0);
    step("t6_pw",   0, 0, 0, 1, PW_OK, 3'd3, 1, 0, 5, 0);
    @(negedge clk);
    password_valid = 0;
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 check_all_zero("held_rst");
    @(negedge clk);
    reset = 1'b0;

    // Password-entry timeout after 64 quiet cycles.
    step("tmo_ent", 1, 0, 0, 0, 4'h0, 3'd1, 0, 1, 0, 0);
    for (int i = 0; i < 63; i++)
      step("tmo_wait", 0, 0, 0, 0, 4'h0, 3'd1, 0, 1, 0, 0);
    step("tmo_idle", 0, 0, 0, 0, 4'h0, 3'd0, 0, 0, 0, 0);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
